// File: rtl/mul56_seq_ctrl.sv
// mul56_seq_ctrl: 56x56 unsigned multiply sequenced over one shared limb multiplier.
// The operands are split into 18/18/20-bit limbs. The 9 limb pairs are shift-accumulated
// into a 112-bit accumulator, one pair per cycle, and the result is held for the consumer.
module mul56_seq_ctrl #(
  parameter int unsigned MUL_SIZE = 56,
  parameter int unsigned RADIX    = 54
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MUL_SIZE-1:0]     a,
  input  logic [MUL_SIZE-1:0]     b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*MUL_SIZE-1:0]   product,
  output logic [1:0]              res_upper,
  output logic [RADIX-1:0]        res_middle,
  output logic                    busy
);

  localparam int unsigned PW  = 2 * MUL_SIZE;  // accumulator / product width
  localparam int unsigned LW  = 20;            // widest limb, narrower limbs zero-extended
  localparam int unsigned PPW = 2 * LW;        // limb product width
  localparam int unsigned SHW = 7;             // shift amount width (max 72)
  localparam int unsigned STW = 4;             // step counter width
  localparam logic [STW-1:0] LAST_STEP = STW'(8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q;
  logic [STW-1:0]      step_q;
  logic [MUL_SIZE-1:0] a_q;
  logic [MUL_SIZE-1:0] b_q;
  logic [PW-1:0]       acc_q;
  logic [PW-1:0]       acc_d;
  logic [PW-1:0]       product_q;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                busy_q;

  logic [1:0]          i_sel;
  logic [1:0]          j_sel;
  logic [LW-1:0]       a_limb;
  logic [LW-1:0]       b_limb;
  logic [SHW-1:0]      a_off;
  logic [SHW-1:0]      b_off;
  logic [PPW-1:0]      pp;

  // Limb pair selection (i = step/3, j = step%3) and next accumulator value.
  always_comb begin
    i_sel = 2'd2;
    j_sel = 2'd2;
    case (step_q)
      4'd0: begin i_sel = 2'd0; j_sel = 2'd0; end
      4'd1: begin i_sel = 2'd0; j_sel = 2'd1; end
      4'd2: begin i_sel = 2'd0; j_sel = 2'd2; end
      4'd3: begin i_sel = 2'd1; j_sel = 2'd0; end
      4'd4: begin i_sel = 2'd1; j_sel = 2'd1; end
      4'd5: begin i_sel = 2'd1; j_sel = 2'd2; end
      4'd6: begin i_sel = 2'd2; j_sel = 2'd0; end
      4'd7: begin i_sel = 2'd2; j_sel = 2'd1; end
      default: begin i_sel = 2'd2; j_sel = 2'd2; end
    endcase

    case (i_sel)
      2'd0:    begin a_limb = LW'(a_q[17:0]);          a_off = SHW'(0);  end
      2'd1:    begin a_limb = LW'(a_q[35:18]);         a_off = SHW'(18); end
      default: begin a_limb = LW'(a_q[MUL_SIZE-1:36]); a_off = SHW'(36); end
    endcase

    case (j_sel)
      2'd0:    begin b_limb = LW'(b_q[17:0]);          b_off = SHW'(0);  end
      2'd1:    begin b_limb = LW'(b_q[35:18]);         b_off = SHW'(18); end
      default: begin b_limb = LW'(b_q[MUL_SIZE-1:36]); b_off = SHW'(36); end
    endcase

    pp    = PPW'(a_limb) * PPW'(b_limb);
    acc_d = acc_q + (PW'(pp) << (a_off + b_off));
  end

  // Controller FSM with registered handshake outputs and held result.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      product_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_q        <= a;
            b_q        <= b;
            acc_q      <= '0;
            step_q     <= '0;
            state_q    <= S_MUL;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          if (step_q >= LAST_STEP) begin
            product_q   <= acc_d;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            step_q <= step_q + STW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          step_q      <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign product    = product_q;
  assign res_upper  = product_q[2*RADIX+3 : 2*RADIX+2];
  assign res_middle = product_q[2*RADIX-1 : RADIX];

endmodule

// File: doc/mul56_seq_ctrl.md
Name: mul56_seq_ctrl

Overview:
- Sequencing controller for a 56x56 unsigned multiplication that reuses one shared limb multiplier, one DSP-slice-sized product per cycle, instead of nine parallel ones.
- Operands are split into three limbs each: [17:0], [35:18] and [55:36]. The controller steps through the 9 limb pairs, shift-accumulates the partial products into a 112-bit accumulator, and presents the full product plus the radix-derived fields (upper 2 bits, middle field) to the downstream reduction logic.
- Valid/ready handshake on both sides.

Parameters:
- MUL_SIZE, 56, operand width. Only 56 is supported because the limb partition is fixed at 18/18/20.
- RADIX, 54, field selector for res_upper and res_middle.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset. One clock; reset is synchronous and active-high.
- in_valid  input  1  operand pair a/b is valid.
- in_ready  output  1  controller can accept operands.
- a  input  MUL_SIZE  multiplicand, unsigned.
- b  input  MUL_SIZE  multiplier, unsigned.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- product  output  2*MUL_SIZE  full product a*b.
- res_upper  output  2  product[2*RADIX+3 : 2*RADIX+2].
- res_middle  output  RADIX  product[2*RADIX-1 : RADIX].
- busy  output  1  high in MUL or DONE.

Behaviour:
- Reset (rst_n=1 at a clock edge):
  - state returns to IDLE, step counter is 0, the accumulator and operand registers are 0.
  - in_ready=1, out_valid=0, busy=0, product=0.
  - Reset takes precedence over every other event, including reset asserted mid-MUL or mid-DONE. An in-flight operation is discarded and never reported.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a and b, clear the accumulator, set step=0, go to MUL.
  - MUL: in_ready=0. Each cycle:
    - i = step/3 (a limb), j = step%3 (b limb).
    - acc += (a_limb[i] * b_limb[j]) << (off[i] + off[j]), with off = {0, 18, 36}.
    - Limb widths are 18, 18 and 20 bits. The product of limbs is at most 40 bits, zero-extended to 112 bits before the shift.
    - step increments. After step 8 is accumulated, go to DONE.
  - DONE: out_valid=1. product, res_upper and res_middle are driven from the accumulator and are stable while out_valid=1 and out_ready=0. On out_ready, go to IDLE.
- Latency:
  - Accept edge is cycle T. Accumulation happens on cycles T+1..T+9. out_valid=1 from cycle T+10.
  - The minimum accept-to-accept interval is 11 cycles when out_ready is held at 1.
- in_valid outside IDLE is ignored; the operands are not latched.
- The latched a and b do not change while MUL or DONE is in progress. Input changes during this time have no effect.
- The accumulator never overflows. The maximum value is (2^56-1)^2 < 2^112, and no carry out of bit 111 exists.
- Outside DONE:
  - out_valid=0.
  - product, res_upper and res_middle hold the last completed value, or 0 after reset. Consumers must qualify them with out_valid.
- The step counter saturates at 8. An illegal state encoding recovers to IDLE.

Test Plan:
- a=1, b=1, accept at cycle T -> out_valid first high at T+10. product=1, res_upper=0, res_middle=0. in_ready=0 from T+1 until the out_ready handshake.
- a=b=2^56-1 -> product=0xFFFFFFFFFFFFFE00000000000001, res_upper=2'b11, res_middle=0x3FFFFFFFFFFFF8.
- a=b=2^55 -> product=2^110, res_upper=2'b01, res_middle=0.
- Limb boundaries:
  - a=0x3FFFF, b=2^35 -> product=0x3FFFF<<35. This checks that b bit 35 is included in limb 1.
  - a=2^36, b=2^36 -> product=2^72.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, and pulse in_valid with new operands meanwhile. Required response:
  - out_valid and product stay constant throughout.
  - in_ready stays 0 and the new operands are ignored.
  - Raising out_ready returns the controller to IDLE on the next cycle.
- Reset mid-operation: assert rst_n during MUL step 4 -> next cycle IDLE, in_ready=1, out_valid=0, product=0. A subsequent a=3, b=5 gives product=15 with no residue from the aborted operation.
